mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative RV32M execute unit. It consumes the funct3 field and the operands that the
//  decode/ALU-control stage issues for an OP instruction with funct7=0000001.
//  It returns the result through a start/busy/done handshake, and the core stalls its
//  EX stage while busy=1.
//  It covers MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
// PARAMETERS
//  XLEN      32   operand/result width; iteration count equals XLEN
// PORTS
//  clk       in   1     rising-edge clock (single clock domain)
//  rst       in   1     asynchronous, active-high reset
//  start     in   1     request; sampled only in IDLE
//  funct3    in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  rs1       in   XLEN  operand A (multiplicand / dividend)
//  rs2       in   XLEN  operand B (multiplier / divisor)
//  busy      out  1     1 from the cycle after start is accepted until done
//  done      out  1     1-cycle pulse; result valid in the same cycle
//  result    out  XLEN  result; held stable until the next accepted start
// BEHAVIOUR
//  - Reset (async): state=IDLE; busy=0, done=0, result=0; all internal registers cleared.
//  - FSM states:
//    - IDLE -> CALC when start=1. funct3, sign flags, |rs1| and |rs2| are latched.
//    - CALC: one radix-2 step per cycle; cnt counts 0..XLEN-1; at cnt=XLEN-1 -> FIX.
//    - FIX: sign correction and upper/lower-half select; result registered -> DONE.
//    - DONE: done=1, busy=0 -> IDLE. A start in DONE is ignored; it must be re-asserted in IDLE.
//  - Latency: start in cycle 0 gives done in cycle XLEN+2 (34 for XLEN=32). No early exit
//    except the special cases below.
//  - busy=1 in CALC and FIX. The start input is ignored while busy, and latched operands
//    are unaffected by input changes.
//  - Multiply:
//    - Shift-add on unsigned magnitudes into a 2*XLEN product.
//    - Signedness: MUL and MULH are signed x signed; MULHSU is rs1 signed x rs2 unsigned;
//      MULHU is unsigned x unsigned.
//    - The product is negated in FIX if the operand signs differ (signed operands only).
//    - MUL returns product[XLEN-1:0]; MULH, MULHSU and MULHU return product[2*XLEN-1:XLEN].
//  - Divide:
//    - Restoring division on magnitudes. The quotient is negated if the signs differ;
//      the remainder takes the sign of the dividend.
//    - DIV/REM are signed, DIVU/REMU unsigned. DIV/DIVU return the quotient, REM/REMU the
//      remainder.
//  - Special cases (detected at accept; skip CALC, go straight to FIX, latency 2):
//    - divisor=0: quotient = all ones for DIV and DIVU; remainder = rs1.
//    - signed overflow (rs1 = 0x8000_0000, rs2 = -1, DIV/REM): quotient=0x8000_0000,
//      remainder=0.
//  - Reset asserted mid-operation: the operation is abandoned immediately, done does not
//    pulse, and outputs return to reset values.
//  - Back-to-back operation: the earliest next accept is the cycle after DONE (IDLE),
//    which gives a throughput of one op per XLEN+3 cycles.
// CONFIGURATION
//  MUL_FAST_EN
//  - Defined: multiplies skip CALC and use a single-cycle combinational XLEN x XLEN
//    multiply in FIX. Multiply latency is 2 (done in cycle 2). Divides are unchanged.
//  - Undefined: all ops use the iterative datapath; no multiplier cell is inferred.
// TESTING
//  1. MUL rs1=7, rs2=-3 (0xFFFF_FFFD) -> result 0xFFFF_FFEB (-21). done at cycle 34,
//     or cycle 2 with MUL_FAST_EN.
//  2. MULH/MULHU/MULHSU with rs1=0x8000_0000, rs2=0xFFFF_FFFF -> MULH 0x0000_0000,
//     MULHU 0x7FFF_FFFF, MULHSU 0x8000_0000.
//  3. DIV -7/2 -> 0xFFFF_FFFD (-3); REM -7/2 -> 0xFFFF_FFFF (-1); DIVU 100/7 -> 14;
//     REMU 100/7 -> 2.
//  4. Divide by 0 with rs1=0x1234: DIV and DIVU -> 0xFFFF_FFFF, REM and REMU -> 0x1234.
//     DIV 0x8000_0000 / -1 -> 0x8000_0000, REM -> 0. All complete with done at cycle 2.
//  5. Handshake:
//     - Pulse start with rs1=6, rs2=5 (MUL); hold start=1 and change rs1/rs2 while busy
//       -> one done pulse, result 30.
//     - A start asserted during DONE is not accepted; a start in the next IDLE cycle is
//       accepted.
//  6. Assert rst in cycle 10 of a DIVU -> busy=0, done=0, result=0 in the same cycle, and
//     no done pulse afterwards. A new MULHU 0xFFFF_FFFF x 0xFFFF_FFFF after reset
//     -> 0xFFFF_FFFE.

Source files
------------

// File: rtl/mul_div_unit_if.sv
// Handshake bundle between the EX stage and the iterative RV32M mul/div unit.
interface mul_div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, rs1, rs2,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, rs1, rs2,
    output busy, done, result
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M execute unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// sign fix-up in a final cycle. Optional macro MUL_FAST_EN replaces the
// iterative multiply with a single-cycle combinational multiply.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  mul_div_unit_if.slave  bus
);

  localparam int              CNT_W   = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       op_q;
  logic             neg_a_q, neg_b_q, div0_q, ovf_q;
  logic [XLEN-1:0]  a_mag_q, b_mag_q;
  logic [XLEN-1:0]  hi_q, lo_q;
  logic [XLEN-1:0]  result_q;

  // Accept-time decode of signedness, magnitudes and special cases
  logic            is_div, sgn_a, sgn_b, neg_a, neg_b, div0, ovf, skip;
  logic [XLEN-1:0] a_mag, b_mag;

  // Decode the incoming request
  always_comb begin
    is_div = bus.funct3[2];
    sgn_a  = is_div ? ~bus.funct3[0] : (bus.funct3 != 3'b011);
    sgn_b  = is_div ? ~bus.funct3[0] : ~bus.funct3[1];
    neg_a  = sgn_a & bus.rs1[XLEN-1];
    neg_b  = sgn_b & bus.rs2[XLEN-1];
    a_mag  = neg_a ? -bus.rs1 : bus.rs1;
    b_mag  = neg_b ? -bus.rs2 : bus.rs2;
    div0   = is_div & (bus.rs2 == '0);
    ovf    = is_div & ~bus.funct3[0] & (bus.rs1 == MIN_NEG) & (bus.rs2 == '1);
`ifdef MUL_FAST_EN
    skip   = div0 | ovf | ~is_div;
`else
    skip   = div0 | ovf;
`endif
  end

  // One radix-2 step for each datapath
  logic [XLEN:0] mul_sum, div_shift, div_diff;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_mag_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_mag_q};
  end

  // Sign correction and half select for the final result
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quot, rem, fix_val;

  always_comb begin
`ifdef MUL_FAST_EN
    prod = {{XLEN{1'b0}}, a_mag_q} * {{XLEN{1'b0}}, b_mag_q};
`else
    prod = {hi_q, lo_q};
`endif
    prod_s = (neg_a_q ^ neg_b_q) ? -prod : prod;
    quot   = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
    rem    = neg_a_q ? -hi_q : hi_q;
    if (div0_q) begin
      quot = '1;
      rem  = neg_a_q ? -a_mag_q : a_mag_q;
    end else if (ovf_q) begin
      quot = MIN_NEG;
      rem  = '0;
    end
    if (op_q[2])
      fix_val = op_q[1] ? rem : quot;
    else if (op_q[1:0] == 2'b00)
      fix_val = prod_s[XLEN-1:0];
    else
      fix_val = prod_s[2*XLEN-1:XLEN];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d  = state_q;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) state_d = skip ? FIX : CALC;
      CALC: begin
        bus.busy = 1'b1;
        if (cnt_q == CNT_W'(XLEN-1)) state_d = FIX;
      end
      FIX: begin
        bus.busy = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, iteration and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.start) begin
          cnt_q   <= '0;
          op_q    <= bus.funct3;
          neg_a_q <= neg_a;
          neg_b_q <= neg_b;
          div0_q  <= div0;
          ovf_q   <= ovf;
          a_mag_q <= a_mag;
          b_mag_q <= b_mag;
          hi_q    <= '0;
          // lo holds the multiplier for multiplies, the dividend for divides
          lo_q    <= is_div ? a_mag : b_mag;
        end
        CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (op_q[2]) begin
            if (!div_diff[XLEN]) begin
              hi_q <= div_diff[XLEN-1:0];
              lo_q <= {lo_q[XLEN-2:0], 1'b1};
            end else begin
              hi_q <= div_shift[XLEN-1:0];
              lo_q <= {lo_q[XLEN-2:0], 1'b0};
            end
          end else begin
            {hi_q, lo_q} <= {mul_sum, lo_q[XLEN-1:1]};
          end
        end
        FIX:     result_q <= fix_val;
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases, handshake, reset
// abort, and random operations against an arithmetic reference model.
module tb_mul_div_unit;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mul_div_unit_if #(.XLEN(XLEN)) bus ();

  mul_div_unit #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference results straight from the RV32M definitions
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub, p;
    logic [63:0] pu;
    int          ia, ib;
    sa = $signed(a);
    sb = $signed(b);
    ub = {32'b0, b};
    ia = a;
    ib = b;
    pu = {32'b0, a} * {32'b0, b};
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: return pu[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int unsigned exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && b == 0) return 2;
    if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`ifdef MUL_FAST_EN
    if (!f3[2]) return 2;
`endif
    return XLEN + 2;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op from IDLE, scramble inputs while busy, check latency/result/pulse
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp;
    int unsigned lat, cyc;
    exp = model(f3, a, b);
    lat = exp_lat(f3, a, b);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = f3; bus.rs1 = a; bus.rs2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.funct3 = 3'($urandom); bus.rs1 = $urandom; bus.rs2 = $urandom;
    cyc = 1;
    check({tag, "/busy"}, 32'(bus.busy), 32'd1);
    while (!bus.done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "/lat"}, cyc, lat);
    check({tag, "/res"}, bus.result, exp);
    @(posedge clk); #1;
    check({tag, "/pulse"}, 32'(bus.done), 32'd0);
    check({tag, "/hold"}, bus.result, exp);
  endtask

  initial begin
    int unsigned cyc, pulses;
    logic [2:0]  f3;
    logic [31:0] a, b;

    bus.start = 1'b0; bus.funct3 = '0; bus.rs1 = '0; bus.rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset/busy", 32'(bus.busy), 32'd0);
    check("reset/done", 32'(bus.done), 32'd0);
    check("reset/result", bus.result, 32'd0);
    rst = 1'b0;

    // Directed arithmetic cases
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7x-3");
    run_op(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, "mulh");
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "mulhu");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_-7/2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_-7/2");
    run_op(3'd5, 32'd100, 32'd7, "divu_100/7");
    run_op(3'd7, 32'd100, 32'd7, "remu_100/7");
    run_op(3'd4, 32'h1234, 32'd0, "div_by0");
    run_op(3'd5, 32'h1234, 32'd0, "divu_by0");
    run_op(3'd6, 32'h1234, 32'd0, "rem_by0");
    run_op(3'd7, 32'h1234, 32'd0, "remu_by0");
    run_op(3'd6, 32'hFFFF_F000, 32'd0, "rem_neg_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

    // Handshake: start held through busy and DONE, operands scrambled
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.rs1 = 32'd6; bus.rs2 = 32'd5;
    cyc = 0; pulses = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      bus.rs1 = $urandom; bus.rs2 = $urandom;
      if (bus.done) pulses++;
    end while (!bus.done && cyc < 100);
    check("hs/lat", cyc, exp_lat(3'd0, 32'd6, 32'd5));
    check("hs/res", bus.result, 32'd30);
    @(posedge clk); #1;
    check("hs/done_start_ignored", 32'(bus.busy), 32'd0);
    check("hs/done_low", 32'(bus.done), 32'd0);
    bus.funct3 = 3'd0; bus.rs1 = 32'd9; bus.rs2 = 32'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("hs/idle_accept", 32'(bus.busy), 32'd1);
    check("hs/one_pulse", pulses, 32'd1);
    cyc = 1;
    while (!bus.done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("hs/res2", bus.result, 32'd36);

    // Reset in the middle of a DIVU
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = 3'd5; bus.rs1 = 32'hDEAD_BEEF; bus.rs2 = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst/busy", 32'(bus.busy), 32'd0);
    check("rst/done", 32'(bus.done), 32'd0);
    check("rst/result", bus.result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) pulses++;
    end
    check("rst/no_done", pulses, 32'd0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_after_rst");

    // Random operations with corner-biased operands
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom);
      a  = pick();
      b  = pick();
      run_op(f3, a, b, $sformatf("rnd%0d_f%0d", i, f3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
